// File: rtl/mul4_fitness_scorer.sv
// Scores candidate 64-bit products against a shift-add golden multiply and
// accumulates bit-match totals per batch of vectors.
module mul4_fitness_scorer #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a1,
  input  logic [15:0]      a0,
  input  logic [15:0]      b1,
  input  logic [15:0]      b0,
  input  logic [15:0]      y3,
  input  logic [15:0]      y2,
  input  logic [15:0]      y1,
  input  logic [15:0]      y0,
  input  logic             last,
  output logic             score_valid,
  input  logic             score_ready,
  output logic [ACC_W-1:0] score,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] perfect_count,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid holds its payload until then, ready never depends on valid.
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, CMP = 2'd2, DONE = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [63:0]        mcand_q, mcand_d;
  logic [31:0]        mplier_q, mplier_d;
  logic [63:0]        prod_q, prod_d;
  logic [63:0]        y_q, y_d;
  logic               last_q, last_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [ACC_W-1:0]   score_q, score_d;
  logic [CNT_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   perf_q, perf_d;
  logic               in_ready_q, in_ready_d;
  logic               score_valid_q, score_valid_d;

  logic [63:0]        match;
  logic [6:0]         pop;
  logic [ACC_W:0]     score_sum;

  always_comb begin
    match = ~(prod_q ^ y_q);
    pop   = '0;
    for (int i = 0; i < 64; i++) begin
      pop = pop + 7'(match[i]);
    end
    score_sum = {1'b0, score_q} + (ACC_W + 1)'(pop);

    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    y_d       = y_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    score_d   = score_q;
    vec_d     = vec_q;
    perf_d    = perf_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mcand_d   = {32'd0, a1, a0};
          mplier_d  = {b1, b0};
          prod_d    = '0;
          y_d       = {y3, y2, y1, y0};
          last_d    = last;
          bit_cnt_d = '0;
          state_d   = MUL;
        end
      end
      MUL: begin
        // One multiplier bit per cycle, LSB first.
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) state_d = CMP;
      end
      CMP: begin
        score_d = score_sum[ACC_W] ? '1 : score_sum[ACC_W-1:0];
        if (vec_q != '1) vec_d = vec_q + CNT_W'(1);
        if ((prod_q == y_q) && (perf_q != '1)) perf_d = perf_q + CNT_W'(1);
        state_d = last_q ? DONE : IDLE;
      end
      DONE: begin
        if (score_ready) begin
          score_d = '0;
          vec_d   = '0;
          perf_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d    = (state_d == IDLE);
    score_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mcand_q       <= '0;
      mplier_q      <= '0;
      prod_q        <= '0;
      y_q           <= '0;
      last_q        <= 1'b0;
      bit_cnt_q     <= '0;
      score_q       <= '0;
      vec_q         <= '0;
      perf_q        <= '0;
      in_ready_q    <= 1'b1;
      score_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      prod_q        <= prod_d;
      y_q           <= y_d;
      last_q        <= last_d;
      bit_cnt_q     <= bit_cnt_d;
      score_q       <= score_d;
      vec_q         <= vec_d;
      perf_q        <= perf_d;
      in_ready_q    <= in_ready_d;
      score_valid_q <= score_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign score_valid   = score_valid_q;
  assign score         = score_q;
  assign vec_count     = vec_q;
  assign perfect_count = perf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Directed bench for mul4_fitness_scorer; narrow accumulators so saturation
// is reachable in a short run.
module tb_mul4_fitness_scorer;

  localparam int ACC_W = 10;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      a1, a0, b1, b0, y3, y2, y1, y0;
  logic             last;
  logic             score_valid;
  logic             score_ready;
  logic [ACC_W-1:0] score;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] perfect_count;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mul4_fitness_scorer #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .last(last), .score_valid(score_valid), .score_ready(score_ready),
    .score(score), .vec_count(vec_count), .perfect_count(perfect_count),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_vec(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] y, input logic lst);
    {a1, a0} = a;
    {b1, b0} = b;
    {y3, y2, y1, y0} = y;
    last = lst;
  endtask

  // Offer one vector, then count edges until the result/ready comes back.
  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] y, input logic lst, input bit disturb);
    int n;
    @(negedge clk);
    drive_vec(a, b, y, lst);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 100) begin
      if (lst ? score_valid : in_ready) break;
      if (disturb) begin
        a1 = 16'($urandom); a0 = 16'($urandom);
        b1 = 16'($urandom); b0 = 16'($urandom);
        y3 = 16'($urandom); y2 = 16'($urandom);
        y1 = 16'($urandom); y0 = 16'($urandom);
        last     = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, 64'(n), 64'd33);
  endtask

  task automatic check_totals(input string tag, input int s, input int v, input int p);
    check({tag, "_score"}, 64'(score), 64'(s));
    check({tag, "_vec"}, 64'(vec_count), 64'(v));
    check({tag, "_perf"}, 64'(perfect_count), 64'(p));
  endtask

  task automatic take_result(input string tag, input int s, input int v, input int p);
    check({tag, "_sv"}, 64'(score_valid), 64'd1);
    check({tag, "_busy"}, 64'(in_ready), 64'd0);
    check_totals(tag, s, v, p);
    @(negedge clk);
    score_ready = 1'b1;
    @(posedge clk);
    #1;
    score_ready = 1'b0;
    check({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
    check({tag, "_sv_after"}, 64'(score_valid), 64'd0);
    check_totals({tag, "_clr"}, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; score_ready = 1'b0;
    drive_vec(32'd0, 32'd0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_sv", 64'(score_valid), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check_totals("rst", 0, 0, 0);

    // 3*5 = 15, exact match
    send("perfect", 32'h3, 32'h5, 64'hF, 1'b1, 1'b0);
    take_result("perfect", 64, 1, 1);

    // P = 0xFFFFFFFE00000001 has 32 ones, so Y=0 matches the 32 zeros
    send("maxop", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 1'b1, 1'b0);
    take_result("maxop", 32, 1, 0);

    // Two-vector batch; running totals visible between vectors
    send("b2v1", 32'h3, 32'h5, 64'hF, 1'b0, 1'b0);
    check("b2_mid_ready", 64'(in_ready), 64'd1);
    check("b2_mid_sv", 64'(score_valid), 64'd0);
    check_totals("b2_mid", 64, 1, 1);
    send("b2v2", 32'h3, 32'h5, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0);
    take_result("b2", 64, 2, 1);

    // Reset during MUL cycle 10 discards partial batch and in-flight vector
    send("pre_abort", 32'h3, 32'h5, 64'hF, 1'b0, 1'b0);
    @(negedge clk);
    drive_vec(32'h3, 32'h5, 64'hF, 1'b1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("abort_in_mul", 64'(dbg_state), 64'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_ready", 64'(in_ready), 64'd1);
    check("abort_sv", 64'(score_valid), 64'd0);
    check_totals("abort", 0, 0, 0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_quiet_sv", 64'(score_valid), 64'd0);
    check_totals("abort_quiet", 0, 0, 0);
    send("post_abort", 32'h3, 32'h5, 64'hF, 1'b1, 1'b0);
    take_result("post_abort", 64, 1, 1);

    // DONE holds while consumer stalls, even with in_valid asserted
    send("hold", 32'h1234, 32'h5678, 64'h0626_0060, 1'b1, 1'b0);
    @(negedge clk);
    drive_vec(32'hAAAA_5555, 32'h0F0F_F0F0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_sv", 64'(score_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
      check_totals("hold", 64, 1, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    take_result("hold", 64, 1, 1);

    // 0xFFFF*0x10001 = 0xFFFFFFFF; Y misses 16 bits, with and without disturbance
    send("calm", 32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_0000, 1'b1, 1'b0);
    take_result("calm", 48, 1, 0);
    send("toggle", 32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_0000, 1'b1, 1'b1);
    take_result("toggle", 48, 1, 0);

    // 17 perfect vectors: score saturates at 1023, counters at 15
    for (int i = 0; i < 16; i++) begin
      send("sat_v", 32'h3, 32'h5, 64'hF, 1'b0, 1'b0);
    end
    check_totals("sat_mid", 1023, 15, 15);
    send("sat_last", 32'h3, 32'h5, 64'hF, 1'b1, 1'b0);
    take_result("sat", 1023, 15, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
